sar_search_ctrl: RTL and testbench
==================================

// Module: sar_search_ctrl
// PURPOSE
//  Initiator side of the comparator interface: drives the probe operand into an
//  external magnitude comparator and consumes its eq/gt/lt flags.
//  Uses successive approximation (binary search) to recover the hidden target operand.
//  Used for threshold/target discovery and for exhaustive comparator bring-up.
// PARAMETERS
//  WIDTH    4  operand width in bits (>=2)
//  CMP_LAT  1  cycles from probe change until cmp_* flags are valid (0..7)
// PORTS
//  clk      in   1      sole clock, rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      begin a search; accepted only while busy=0
//  busy     out  1      search in progress
//  done     out  1      one-cycle pulse: result/found/err valid
//  probe    out  WIDTH  operand driven to comparator input b
//  cmp_eq   in   1      comparator: target == probe
//  cmp_gt   in   1      comparator: target >  probe
//  cmp_lt   in   1      comparator: target <  probe
//  result   out  WIDTH  recovered target; held until next accepted start
//  found    out  1      final verify compare returned eq
//  err      out  1      flags were not one-hot at a sample point
// BEHAVIOUR
//  Reset: busy=0 done=0 probe=0 result=0 found=0 err=0; FSM state=IDLE; acc=0.
//  States: IDLE -> STEP -> VERIFY -> FIN -> IDLE.
//  IDLE: start=1 -> clear acc/found/err, bit index i=WIDTH-1, busy=1, go to STEP.
//  STEP(i): probe = acc | (1<<i), held for CMP_LAT+1 cycles; flags sampled on the last cycle.
//   gt -> acc[i]=1; lt -> acc[i]=0; eq -> acc[i]=1 (and see CONFIGURATION).
//   i==0 after the sample -> VERIFY; otherwise i-1 and stay in STEP.
//  VERIFY: probe = acc for CMP_LAT+1 cycles; found = cmp_eq at the sample; -> FIN.
//  FIN: result=acc, done=1 for one cycle, busy=0; returns to IDLE on the next cycle.
//  Latency: start seen at edge k -> done high in cycle k+(WIDTH+1)*(CMP_LAT+1)+1.
//  Any sample with flags not exactly one-hot: err=1, found=0, result=acc, immediate FIN.
//  start while busy=1: ignored, no effect.
//  start in the same cycle as done: accepted, because busy is already 0.
//  rst mid-search: abort to reset values on the next edge; done is not pulsed.
//  probe changes only at step boundaries; it is registered and glitch-free.
//  Arithmetic: pure bit set/clear on acc; no adders; WIDTH-wide throughout.
// CONFIGURATION
//  SAR_EARLY_EXIT_EN defined:
//   - eq during a STEP sets acc = probe and found=1, then jumps straight to FIN.
//   - Latency becomes variable; the worst case is unchanged.
//  Not defined:
//   - Every search runs all WIDTH steps plus VERIFY, giving fixed, deterministic latency.
// STRUCTURE
//  Package sar_search_pkg:
//   - state_t enum {IDLE, STEP, VERIFY, FIN}
//   - flag-decode function one-hot check returning {valid, eq, gt, lt}
//   - localparam CNT_W = $clog2(CMP_LAT+1)
//  Sub-module sar_step_timer:
//   - settle counter; loads on step entry and asserts sample on the final cycle
//   - with CMP_LAT=0, sample is asserted every cycle
//  Top module holds the FSM, acc, the i counter and the output registers.
// TESTING (bench models comparator with a CMP_LAT-deep flag pipeline)
//  WIDTH=4, CMP_LAT=1, target=9, start @k:
//   - probes 8,12,10,9, then verify 9
//   - done @k+11 with result=9, found=1, err=0
//  target=0:
//   - probes 8,4,2,1, then verify 0
//   - result=0, found=1
//  target=15:
//   - probes 8,12,14,15, then verify 15
//   - result=15, found=1
//  Fault injection: force gt=lt=1 on the second step sample:
//   - err=1, found=0, done two cycles after the fault sample
//  start pulsed mid-search: ignored; rst during step 3: all outputs return to 0
//  next start: completes normally, result=9
//  SAR_EARLY_EXIT_EN, target=8: first probe 8 returns eq -> done @k+3, result=8, found=1

Source files
------------

// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    VERIFY,
    FIN
  } state_t;

  typedef struct packed {
    logic valid;
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

  // Counter is sized for the largest supported settle latency so one width serves every build.
  localparam int CMP_LAT_MAX = 7;
  localparam int CNT_W       = $clog2(CMP_LAT_MAX + 1);

  function automatic flags_t decode_flags(input logic eq, input logic gt, input logic lt);
    flags_t f;
    f.valid = (eq & ~gt & ~lt) | (~eq & gt & ~lt) | (~eq & ~gt & lt);
    f.eq    = eq;
    f.gt    = gt;
    f.lt    = lt;
    return f;
  endfunction

endpackage

// File: rtl/sar_step_timer.sv
// Settle timer: reloads on step entry, flags the final cycle of each CMP_LAT+1 cycle window.
module sar_step_timer
  import sar_search_pkg::*;
#(
  parameter int CMP_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic sample_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(CMP_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_o = (cnt_q == '0);

endmodule

// File: rtl/sar_search_ctrl.sv
// Binary-search initiator that recovers a hidden operand through an external comparator.
// Optional build macro SAR_EARLY_EXIT_EN: finish as soon as a step probe compares equal.
module sar_search_ctrl
  import sar_search_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] probe_o,
  input  logic             cmp_eq_i,
  input  logic             cmp_gt_i,
  input  logic             cmp_lt_i,
  output logic [WIDTH-1:0] result_o,
  output logic             found_o,
  output logic             err_o
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  logic             sample;
  logic             timer_load;
  logic [WIDTH-1:0] bit_mask;
  flags_t           flags;

  assign bit_mask = ONE << idx_q;
  assign flags    = decode_flags(cmp_eq_i, cmp_gt_i, cmp_lt_i);

  sar_step_timer #(
    .CMP_LAT (CMP_LAT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (timer_load),
    .sample_o (sample)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = STEP;
      STEP: begin
        if (sample) begin
          if (!flags.valid) begin
            state_d = FIN;
`ifdef SAR_EARLY_EXIT_EN
          end else if (flags.eq) begin
            state_d = FIN;
`endif
          end else if (idx_q == '0) begin
            state_d = VERIFY;
          end
        end
      end
      VERIFY: if (sample) state_d = FIN;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit decisions are pure set/clear; the next probe is formed before the shared register update.
  always_comb begin
    acc_d      = acc_q;
    idx_d      = idx_q;
    probe_d    = probe_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    found_d    = found_q;
    err_d      = err_q;
    timer_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d      = '0;
          found_d    = 1'b0;
          err_d      = 1'b0;
          result_d   = '0;
          idx_d      = IDX_W'(WIDTH - 1);
          probe_d    = ONE << (WIDTH - 1);
          busy_d     = 1'b1;
          timer_load = 1'b1;
        end
      end
      STEP: begin
        if (sample) begin
          if (!flags.valid) begin
            err_d   = 1'b1;
            found_d = 1'b0;
`ifdef SAR_EARLY_EXIT_EN
          end else if (flags.eq) begin
            acc_d   = probe_q;
            found_d = 1'b1;
`endif
          end else begin
            acc_d      = flags.lt ? (acc_q & ~bit_mask) : (acc_q | bit_mask);
            timer_load = 1'b1;
            if (idx_q == '0) begin
              probe_d = acc_d;
            end else begin
              idx_d   = idx_q - IDX_W'(1);
              probe_d = acc_d | (bit_mask >> 1);
            end
          end
        end
      end
      VERIFY: begin
        if (sample) begin
          err_d   = ~flags.valid;
          found_d = flags.valid & flags.eq;
        end
      end
      FIN: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      idx_q    <= '0;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign probe_o  = probe_q;
  assign result_o = result_q;
  assign found_o  = found_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench: comparator with a CMP_LAT-deep flag pipeline and a plain binary-search model.
module tb_sar_search_ctrl;

  localparam int W   = 4;
  localparam int LAT = 1;
  localparam int PER = LAT + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy_o, done_o, found_o, err_o;
  logic [W-1:0] probe_o, result_o;
  logic         cmp_eq, cmp_gt, cmp_lt;
  logic [W-1:0] target;
  logic         fault;
  logic [W-1:0] seenProbe;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  sar_search_ctrl #(
    .WIDTH   (W),
    .CMP_LAT (LAT)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .probe_o  (probe_o),
    .cmp_eq_i (cmp_eq),
    .cmp_gt_i (cmp_gt),
    .cmp_lt_i (cmp_lt),
    .result_o (result_o),
    .found_o  (found_o),
    .err_o    (err_o)
  );

  // Comparator flags see the probe LAT cycles late
  generate
    if (LAT == 0) begin : g_nolat
      assign seenProbe = probe_o;
    end else begin : g_lat
      logic [W-1:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= probe_o;
        for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
      end
      assign seenProbe = pipe[LAT-1];
    end
  endgenerate

  assign cmp_eq = fault ? 1'b0 : (seenProbe == target);
  assign cmp_gt = fault ? 1'b1 : (target > seenProbe);
  assign cmp_lt = fault ? 1'b1 : (target < seenProbe);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one search from the current cycle; returns in the cycle where done is expected high.
  task automatic applyStimulus(input logic [W-1:0] tgt, input int faultStep, input bit midStart);
    logic [W-1:0] expProbe[$];
    logic [W-1:0] acc, p, expResult;
    logic         expFound, expErr;
    bit           stopped;
    int           nSamples, doneCyc, pInt;
    acc = '0; expFound = 1'b0; expErr = 1'b0; stopped = 1'b0; nSamples = 0; expResult = '0;
    for (int i = W - 1; i >= 0; i--) begin
      pInt = int'(acc) + (1 << i);
      p    = W'(pInt);
      expProbe.push_back(p);
      nSamples++;
      if (faultStep == nSamples - 1) begin
        expErr = 1'b1; expResult = acc; stopped = 1'b1;
        break;
      end
`ifdef SAR_EARLY_EXIT_EN
      if (p == tgt) begin
        expFound = 1'b1; expResult = p; stopped = 1'b1;
        break;
      end
`endif
      if (int'(tgt) >= pInt) acc = p;
    end
    if (!stopped) begin
      expProbe.push_back(acc);
      nSamples++;
      expResult = acc;
      if (faultStep == W) expErr = 1'b1;
      else expFound = (acc == tgt);
    end
    doneCyc = nSamples * PER + 1;

    target = tgt;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    for (int c = 0; c <= doneCyc; c++) begin
      fault = (faultStep >= 0) && (c == faultStep * PER + LAT);
      start = midStart && (c == 3);
      if (c < nSamples * PER) begin
        checkOutput("probe", 32'(probe_o), 32'(expProbe[c / PER]));
        checkOutput("busy_run", 32'(busy_o), 32'd1);
      end
      if (c < doneCyc) begin
        checkOutput("done_low", 32'(done_o), 32'd0);
        @(posedge clk); #1;
      end else begin
        checkOutput("done", 32'(done_o), 32'd1);
        checkOutput("result", 32'(result_o), 32'(expResult));
        checkOutput("found", 32'(found_o), 32'(expFound));
        checkOutput("err", 32'(err_o), 32'(expErr));
        checkOutput("busy_done", 32'(busy_o), 32'd0);
      end
    end
    fault = 1'b0;
    start = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_done", 32'(done_o), 32'd0);
    end
  endtask

  task automatic resetMidSearch();
    target = 4'd9;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("busy_pre_rst", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_probe", 32'(probe_o), 32'd0);
    checkOutput("rst_result", 32'(result_o), 32'd0);
    checkOutput("rst_found", 32'(found_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    rst = 1'b0;
    idleCycles(12);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fault = 1'b0; target = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_probe", 32'(probe_o), 32'd0);
    checkOutput("reset_result", 32'(result_o), 32'd0);
    checkOutput("reset_found", 32'(found_o), 32'd0);
    checkOutput("reset_err", 32'(err_o), 32'd0);
    rst = 1'b0;
    idleCycles(2);

    applyStimulus(4'd9, -1, 1'b0);
    idleCycles(1);
    applyStimulus(4'd0, -1, 1'b0);
    idleCycles(1);
    applyStimulus(4'd15, -1, 1'b0);
    idleCycles(1);
    applyStimulus(4'd9, 1, 1'b0);
    idleCycles(1);
    applyStimulus(4'd8, -1, 1'b0);
    idleCycles(1);
    applyStimulus(4'd5, -1, 1'b1);
    applyStimulus(4'd3, -1, 1'b0);
    applyStimulus(4'd12, W, 1'b0);
    idleCycles(1);
    resetMidSearch();
    applyStimulus(4'd9, -1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] t;
      int fs;
      t  = W'($urandom_range(0, (1 << W) - 1));
      fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1;
      applyStimulus(t, fs, 1'(($urandom_range(0, 4) == 0)));
      idleCycles(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount + 1);
    $fatal(1, "[TB] time limit");
  end

endmodule
